addsub_seq: RTL and testbench

Multi-cycle controller that time-shares one 8-bit add/subtract slice (`addsub8`) to produce full-width add, subtract and compare results, one byte per clock, LSB first. It sits between the decode/ALU control of the small RISC-V core and the byte-wide arithmetic datapath. It trades latency for area on the iCE40 UltraPlus target.

---
 rtl/addsub_seq_pkg.sv | 17 +
 rtl/addsub_seq_addsub8.sv | 16 +
 rtl/addsub_seq.sv | 147 ++++++++++++++
 tb/tb_addsub_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract controller.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ADDSUB_SEQ_NBYTES_DEF = 4;

  // Byte index width; a single-byte build still needs a 1-bit counter.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_addsub8.sv
// 8-bit add/subtract slice: sum = a + (sub ? ~b : b) + cin.
module addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};

endmodule

// File: rtl/addsub_seq.sv
// Byte-serial W-bit add/subtract/compare using one addsub8 slice, LSB first.
// Compare flags are built only when ADDSUB_SEQ_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | ready, waiting for start; result/cout/flags hold
// RUN   | one byte per cycle through the slice, idx 0..NBYTES-1
// DONE  | one-cycle done pulse, then back to IDLE
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int NBYTES = ADDSUB_SEQ_NBYTES_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic                ovf,
  output logic                lt,
  output logic                ltu
);

  localparam int IW = idx_width(NBYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  state_e                  state;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    sub_q;
  logic                    cout_q;
  logic [NBYTES-1:0][7:0]  a_q;
  logic [NBYTES-1:0][7:0]  b_q;
  logic [NBYTES-1:0][7:0]  res_q;

  logic       s_cin;
  logic       s_cout;
  logic [7:0] s_sum;
  logic       last_byte;

  assign s_cin     = (idx == '0) ? sub_q : carry;
  assign last_byte = (idx == IDX_LAST);

  addsub8 u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .sub  (sub_q),
    .cin  (s_cin),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cout_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            res_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          res_q[idx] <= s_sum;
          carry      <= s_cout;
          // cout is captured with the MSB byte so it is valid alongside done
          if (last_byte) begin
            cout_q <= s_cout;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign result = res_q;
  assign cout   = cout_q;

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic zacc;
  logic zero_q;
  logic ovf_q;
  logic lt_q;
  logic ltu_q;
  logic b_msb_eff;
  logic ovf_next;

  assign b_msb_eff = b_q[NBYTES-1][7] ^ sub_q;
  assign ovf_next  = (a_q[NBYTES-1][7] == b_msb_eff) && (s_sum[7] != a_q[NBYTES-1][7]);

  // zero is an OR-accumulator over bytes, resolved with the MSB byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zacc   <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      lt_q   <= 1'b0;
      ltu_q  <= 1'b0;
    end else if (state == IDLE && start) begin
      zacc <= 1'b0;
    end else if (state == RUN) begin
      zacc <= zacc | (|s_sum);
      if (last_byte) begin
        zero_q <= ~(zacc | (|s_sum));
        ovf_q  <= ovf_next;
        lt_q   <= s_sum[7] ^ ovf_next;
        ltu_q  <= ~s_cout;
      end
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign lt   = lt_q;
  assign ltu  = ltu_q;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
  assign lt   = 1'b0;
  assign ltu  = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (NBYTES = 4).
module tb_addsub_seq;
  import addsub_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        ovf;
  logic        lt;
  logic        ltu;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  addsub_seq #(.NBYTES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf),
    .lt     (lt),
    .ltu    (ltu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // eflg = {zero, ovf, lt, ltu}
  task automatic chk_flags(input string tag, input logic [3:0] eflg);
`ifdef ADDSUB_SEQ_FLAGS_EN
    chk(tag, {60'd0, zero, ovf, lt, ltu}, {60'd0, eflg});
`else
    chk(tag, {60'd0, zero, ovf, lt, ltu}, 64'd0);
`endif
  endtask

  // One operation; with poke set, a conflicting start is pulsed in the second RUN cycle.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] eres, input logic ecout,
                        input logic [3:0] eflg, input bit poke);
    int n;
    @(negedge clk);
    chk({tag, " ready"}, {63'd0, ready}, 64'd1);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      start = poke && (n == 2);
      if (poke && n == 2) begin
        a = ~ia; b = ~ib; sub = ~isub;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd5);
    chk({tag, " result"}, {32'd0, result}, {32'd0, eres});
    chk({tag, " cout"}, {63'd0, cout}, {63'd0, ecout});
    chk_flags({tag, " flags"}, eflg);
    @(negedge clk);
    chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
    chk({tag, " ready back"}, {63'd0, ready}, 64'd1);
    chk({tag, " hold"}, {32'd0, result}, {32'd0, eres});
  endtask

  logic [31:0] ta [3] = '{32'h0000_0001, 32'h0000_0010, 32'hFFFF_FFFF};
  logic [31:0] tb [3] = '{32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF};
  logic        ts [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] tr [3] = '{32'h0000_0003, 32'h0000_000F, 32'hFFFF_FFFE};
  logic        tc [3] = '{1'b0, 1'b1, 1'b1};
  logic [3:0]  tf [3] = '{4'b0001, 4'b0000, 4'b0010};
  int          acc [3];

  initial begin
    int n;
    int dones;
    resetn = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    chk("rst ready", {63'd0, ready}, 64'd1);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst result", {32'd0, result}, 64'd0);
    chk("rst cout", {63'd0, cout}, 64'd0);
    chk("rst flags", {60'd0, zero, ovf, lt, ltu}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 4'b0001, 1'b0);
    run_op("sub_0_1",   32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0011, 1'b0);
    run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 4'b0101, 1'b0);
    run_op("sub_eq",    32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 4'b1000, 1'b0);
    run_op("busy_poke", 32'h0000_00AA, 32'h0000_0055, 1'b0, 32'h0000_00FF, 1'b0, 4'b0001, 1'b1);

    // Reset during the second RUN cycle
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid byte0", {32'd0, result}, 64'h33);
    resetn = 1'b0;
    #1;
    chk("mid rst ready", {63'd0, ready}, 64'd1);
    chk("mid rst result", {32'd0, result}, 64'd0);
    chk("mid rst done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort no done", 64'(dones), 64'd0);
    run_op("post_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4'b1000, 1'b0);

    // start held high across three back-to-back operations
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      a = ta[i]; b = tb[i]; sub = ts[i];
      acc[i] = cyc;
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("stream%0d result", i), {32'd0, result}, {32'd0, tr[i]});
      chk($sformatf("stream%0d cout", i), {63'd0, cout}, {63'd0, tc[i]});
      chk_flags($sformatf("stream%0d flags", i), tf[i]);
      if (i > 0) chk($sformatf("stream%0d spacing", i), 64'(acc[i] - acc[i-1]), 64'd6);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
